// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo: single-clock receive FIFO between the link receiver and the
// RMAP command decoder. The MSB of each word is the end-of-packet flag.
// Every stored word, including the one presented in first-word-fall-through
// mode, stays in the memory. In that mode dataOut is a registered copy of the
// head word, and the count includes that head word.
module rx_packet_fifo #(
  parameter int WIDTH       = 9,
  parameter int DEPTH       = 64,
  parameter int FWFT        = 0,
  parameter int AFULL_LEVEL = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     writeEnable,
  input  logic [WIDTH-1:0]         dataIn,
  output logic                     full,
  output logic                     almostFull,
  input  logic                     readEnable,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     packetAvailable,
  output logic [$clog2(DEPTH):0]   packetCount,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_packetCount;
  logic [WIDTH-1:0]  r_dataOut;
  logic              r_empty;
  logic              r_full;
  logic              r_almostFull;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_clear;
  logic              w_rdAccept;
  logic              w_wrAccept;
  logic              w_wrEop;
  logic              w_rdEop;
  logic [WIDTH-1:0]  w_headWord;
  logic [ADDR_W-1:0] w_wrPtrNext;
  logic [ADDR_W-1:0] w_rdPtrNext;
  logic [ADDR_W:0]   w_countNext;
  logic [ADDR_W:0]   w_packetCountNext;
  logic [ADDR_W:0]   w_remaining;
  logic [WIDTH-1:0]  w_prefetchWord;
  logic [WIDTH-1:0]  w_dataOutNext;

  assign w_clear    = reset | flush;
  assign w_rdAccept = readEnable & ~r_empty;
  assign w_wrAccept = writeEnable & (~r_full | w_rdAccept);
  assign w_headWord = r_mem[r_rdPtr];
  assign w_wrEop    = w_wrAccept & dataIn[WIDTH-1];
  assign w_rdEop    = w_rdAccept & w_headWord[WIDTH-1];

  // Next pointers, occupancy, packet count and the next value of dataOut
  always_comb begin
    w_wrPtrNext       = r_wrPtr;
    w_rdPtrNext       = r_rdPtr;
    w_countNext       = r_count;
    w_packetCountNext = r_packetCount;
    w_remaining       = r_count;
    w_prefetchWord    = r_mem[r_rdPtr];
    w_dataOutNext     = r_dataOut;

    if (w_wrAccept) w_wrPtrNext = r_wrPtr + ADDR_W'(1);
    if (w_rdAccept) begin
      w_rdPtrNext = r_rdPtr + ADDR_W'(1);
      w_remaining = r_count - (ADDR_W+1)'(1);
    end

    if (w_wrAccept && !w_rdAccept)      w_countNext = r_count + (ADDR_W+1)'(1);
    else if (w_rdAccept && !w_wrAccept) w_countNext = r_count - (ADDR_W+1)'(1);

    if (w_wrEop && !w_rdEop)      w_packetCountNext = r_packetCount + (ADDR_W+1)'(1);
    else if (w_rdEop && !w_wrEop) w_packetCountNext = r_packetCount - (ADDR_W+1)'(1);

    // When no older word survives this cycle, the incoming word becomes the head
    // and must bypass the memory, which is only written on the clock edge.
    if (w_wrAccept && (w_remaining == '0)) w_prefetchWord = dataIn;
    else                                   w_prefetchWord = r_mem[w_rdPtrNext];

    if (FWFT != 0) begin
      if (w_countNext != '0) w_dataOutNext = w_prefetchWord;
    end else begin
      if (w_rdAccept) w_dataOutNext = w_headWord;
    end
  end

  // Storage array, kept free of reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (!w_clear && w_wrAccept) r_mem[r_wrPtr] <= dataIn;
  end

  // Control state: pointers, counts, registered status flags and output data
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_packetCount <= '0;
      r_dataOut     <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almostFull  <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_wrPtr       <= w_wrPtrNext;
      r_rdPtr       <= w_rdPtrNext;
      r_count       <= w_countNext;
      r_packetCount <= w_packetCountNext;
      r_dataOut     <= w_dataOutNext;
      r_empty       <= (w_countNext == '0);
      r_full        <= (w_countNext == (ADDR_W+1)'(DEPTH));
      r_almostFull  <= (w_countNext >= (ADDR_W+1)'(AFULL_LEVEL));
      if (writeEnable && r_full && !w_rdAccept) r_overflow  <= 1'b1;
      if (readEnable && r_empty)                r_underflow <= 1'b1;
    end
  end

  assign full            = r_full;
  assign almostFull      = r_almostFull;
  assign dataOut         = r_dataOut;
  assign empty           = r_empty;
  assign count           = r_count;
  assign packetAvailable = (r_packetCount != '0);
  assign packetCount     = r_packetCount;
  assign overflow        = r_overflow;
  assign underflow       = r_underflow;

endmodule

// File: tb/tb_rx_packet_fifo.sv
// tb_rx_packet_fifo: directed bench for rx_packet_fifo. It uses WIDTH=9,
// DEPTH=8 and AFULL_LEVEL=6, with one instance in registered-read mode and a
// second instance in first-word-fall-through mode. Both instances share the
// same inputs.
module tb_rx_packet_fifo;

  localparam int WIDTH = 9;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             writeEnable = 1'b0;
  logic             readEnable = 1'b0;
  logic [WIDTH-1:0] dataIn = '0;

  logic             full0, almostFull0, empty0, packetAvailable0, overflow0, underflow0;
  logic [WIDTH-1:0] dataOut0;
  logic [CW-1:0]    count0, packetCount0;
  logic             full1, almostFull1, empty1, packetAvailable1, overflow1, underflow1;
  logic [WIDTH-1:0] dataOut1;
  logic [CW-1:0]    count1, packetCount1;

  int checks = 0;
  int failures = 0;

  rx_packet_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AFULL_LEVEL(6)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .writeEnable(writeEnable), .dataIn(dataIn),
    .full(full0), .almostFull(almostFull0),
    .readEnable(readEnable), .dataOut(dataOut0), .empty(empty0),
    .count(count0), .packetAvailable(packetAvailable0), .packetCount(packetCount0),
    .overflow(overflow0), .underflow(underflow0)
  );

  rx_packet_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AFULL_LEVEL(6)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .writeEnable(writeEnable), .dataIn(dataIn),
    .full(full1), .almostFull(almostFull1),
    .readEnable(readEnable), .dataOut(dataOut1), .empty(empty1),
    .count(count1), .packetAvailable(packetAvailable1), .packetCount(packetCount1),
    .overflow(overflow1), .underflow(underflow1)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then wait until just after the active edge
  task automatic applyStimulus(input logic we, input logic re, input logic [WIDTH-1:0] din);
    writeEnable = we;
    readEnable  = re;
    dataIn      = din;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse a clear (reset when useReset=1, otherwise flush) for one cycle
  task automatic pulseClear(input logic useReset);
    if (useReset) reset = 1'b1;
    else          flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
  endtask

  // Directed test sequence
  initial begin
    @(negedge clk);
    pulseClear(1'b1);
    checkOutput("rst_count",     32'(count0), 32'd0);
    checkOutput("rst_empty",     32'(empty0), 32'd1);
    checkOutput("rst_full",      32'(full0), 32'd0);
    checkOutput("rst_dataOut",   32'(dataOut0), 32'd0);
    checkOutput("rst_overflow",  32'(overflow0), 32'd0);
    checkOutput("rst_underflow", 32'(underflow0), 32'd0);
    checkOutput("rst_pktAvail",  32'(packetAvailable0), 32'd0);

    // Fill with 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, WIDTH'(i));
      checkOutput($sformatf("fill_count_%0d", i), 32'(count0), 32'(i));
      checkOutput($sformatf("fill_afull_%0d", i), 32'(almostFull0), (i >= 6) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill_full_%0d", i),  32'(full0), (i == 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill_empty_%0d", i), 32'(empty0), 32'd0);
    end

    // Overflow attempt while full
    applyStimulus(1'b1, 1'b0, 9'h0AA);
    checkOutput("ovf_flag",  32'(overflow0), 32'd1);
    checkOutput("ovf_count", 32'(count0), 32'd8);

    // Drain: data arrives one cycle after each readEnable
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput($sformatf("drain_data_%0d", i),  32'(dataOut0), 32'(i));
      checkOutput($sformatf("drain_count_%0d", i), 32'(count0), 32'(8 - i));
    end
    checkOutput("drain_empty", 32'(empty0), 32'd1);
    checkOutput("drain_full",  32'(full0), 32'd0);

    // Underflow: read while empty, dataOut holds
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("udf_flag",     32'(underflow0), 32'd1);
    checkOutput("udf_dataOut",  32'(dataOut0), 32'h008);
    checkOutput("ovf_sticky",   32'(overflow0), 32'd1);

    // Fill with 0x010..0x017 then simultaneous write/read for 12 cycles
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, WIDTH'(9'h010 + i));
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b1, WIDTH'(9'h020 + k));
      checkOutput($sformatf("simul_count_%0d", k), 32'(count0), 32'd8);
      checkOutput($sformatf("simul_data_%0d", k), 32'(dataOut0),
                  (k < 8) ? 32'(9'h010 + k) : 32'(9'h020 + (k - 8)));
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput($sformatf("wrap_data_%0d", j), 32'(dataOut0), 32'(9'h024 + j));
    end
    checkOutput("wrap_empty", 32'(empty0), 32'd1);

    // Simultaneous write and read while empty
    pulseClear(1'b0);
    checkOutput("flush_udf", 32'(underflow0), 32'd0);
    applyStimulus(1'b1, 1'b1, 9'h033);
    checkOutput("emptysim_count", 32'(count0), 32'd1);
    checkOutput("emptysim_udf",   32'(underflow0), 32'd1);
    checkOutput("emptysim_empty", 32'(empty0), 32'd0);
    checkOutput("emptysim_dout",  32'(dataOut0), 32'd0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("emptysim_read",  32'(dataOut0), 32'h033);
    checkOutput("emptysim_count0", 32'(count0), 32'd0);

    // Packet tracking
    pulseClear(1'b0);
    applyStimulus(1'b1, 1'b0, 9'h041);
    applyStimulus(1'b1, 1'b0, 9'h042);
    applyStimulus(1'b1, 1'b0, 9'h100);
    checkOutput("pkt_cnt_first", 32'(packetCount0), 32'd1);
    applyStimulus(1'b1, 1'b0, 9'h043);
    applyStimulus(1'b1, 1'b0, 9'h101);
    checkOutput("pkt_cnt",   32'(packetCount0), 32'd2);
    checkOutput("pkt_avail", 32'(packetAvailable0), 32'd1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("pkt_rd1", 32'(packetCount0), 32'd2);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("pkt_rd3_data",  32'(dataOut0), 32'h100);
    checkOutput("pkt_rd3_cnt",   32'(packetCount0), 32'd1);
    checkOutput("pkt_rd3_avail", 32'(packetAvailable0), 32'd1);

    // FWFT instance: fall-through and back-to-back pops
    pulseClear(1'b0);
    applyStimulus(1'b1, 1'b0, 9'h055);
    checkOutput("fwft_empty",  32'(empty1), 32'd0);
    checkOutput("fwft_dout",   32'(dataOut1), 32'h055);
    checkOutput("fwft_count",  32'(count1), 32'd1);
    applyStimulus(1'b1, 1'b0, 9'h056);
    applyStimulus(1'b1, 1'b0, 9'h057);
    checkOutput("fwft_hold",   32'(dataOut1), 32'h055);
    checkOutput("fwft_count3", 32'(count1), 32'd3);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("fwft_pop1_dout",  32'(dataOut1), 32'h056);
    checkOutput("fwft_pop1_count", 32'(count1), 32'd2);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("fwft_pop2_dout",  32'(dataOut1), 32'h057);
    checkOutput("fwft_pop2_empty", 32'(empty1), 32'd0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("fwft_pop3_empty", 32'(empty1), 32'd1);
    checkOutput("fwft_pop3_dout",  32'(dataOut1), 32'h057);
    checkOutput("fwft_pop3_udf",   32'(underflow1), 32'd0);

    // Flush then reset mid-operation with 5 words stored and overflow set
    for (int pass = 0; pass < 2; pass++) begin
      pulseClear(1'b0);
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, WIDTH'(9'h060 + i));
      applyStimulus(1'b1, 1'b0, 9'h0AA);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0);
      checkOutput($sformatf("mid_pre_count_%0d", pass), 32'(count0), 32'd5);
      checkOutput($sformatf("mid_pre_ovf_%0d", pass),   32'(overflow0), 32'd1);
      checkOutput($sformatf("mid_pre_dout_%0d", pass),  32'(dataOut0), 32'h063);
      writeEnable = 1'b1;
      readEnable  = 1'b1;
      dataIn      = 9'h1FF;
      pulseClear(pass == 1);
      writeEnable = 1'b0;
      readEnable  = 1'b0;
      checkOutput($sformatf("mid_count_%0d", pass), 32'(count0), 32'd0);
      checkOutput($sformatf("mid_empty_%0d", pass), 32'(empty0), 32'd1);
      checkOutput($sformatf("mid_ovf_%0d", pass),   32'(overflow0), 32'd0);
      checkOutput($sformatf("mid_dout_%0d", pass),  32'(dataOut0), 32'd0);
      checkOutput($sformatf("mid_pkt_%0d", pass),   32'(packetCount0), 32'd0);
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput($sformatf("mid_after_count_%0d", pass), 32'(count0), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_packet_fifo.md
Name: rx_packet_fifo

Overview:
- Parametrised successor to the single-width receive FIFO in the SpaceWire/RMAP receive path.
- Buffers WIDTH-bit receive words. The MSB is the control flag: MSB=1 marks an end-of-packet word (EOP/EEP).
- Adds selectable read mode, occupancy count, complete-packet tracking, almost-full threshold, sticky error flags and flush.
- Sits between the link receiver (write side) and the RMAP command decoder (read side). Both sides use the same clock.

Parameters:
- WIDTH, 9, word width in bits. Bit WIDTH-1 is the control flag. Legal range: 2 or more.
- DEPTH, 64, number of words stored. Must be a power of two and 4 or more. ADDR_W = clog2(DEPTH).
- FWFT, 0, read mode. 0 = registered read: data appears one cycle after readEnable. 1 = first-word-fall-through: the head word is always presented.
- AFULL_LEVEL, DEPTH-4, almostFull asserts when count >= AFULL_LEVEL. Legal range: 1 to DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents and flags.
- writeEnable  in  1  write request.
- dataIn  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almostFull  out  1  count >= AFULL_LEVEL.
- readEnable  in  1  read (pop) request.
- dataOut  out  WIDTH  read data.
- empty  out  1  no word is available to read (meaning in FWFT mode defined under Behaviour).
- count  out  ADDR_W+1  words stored (FWFT: includes the presented head word).
- packetAvailable  out  1  packetCount != 0.
- packetCount  out  ADDR_W+1  number of stored end-of-packet words.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
Reset and flush
- Reset and flush act identically and take priority over any same-cycle write or read.
- Values after reset/flush: pointers=0, count=0, packetCount=0, dataOut=0, empty=1, full=0, almostFull=0, packetAvailable=0, overflow=0, underflow=0.

Accept rules
- A write is accepted when writeEnable=1 and (full=0, or a read is accepted in the same cycle).
- A read is accepted when readEnable=1 and empty=0.
- Write while full with no accepted read: data is dropped, overflow is set. Contents are unchanged.
- Read while empty: ignored, underflow is set. dataOut holds its value.
- Write and read accepted in the same cycle: count is unchanged, both pointers advance.
- Write and read in the same cycle while empty: the write is accepted, the read is rejected, underflow is set.

Pointers and count
- Pointers are ADDR_W bits and wrap from DEPTH-1 to 0.
- count is updated in the cycle after each operation: +1 for an accepted write only, -1 for an accepted read only.
- full, almostFull and empty are registered. They are consistent with count in the same cycle.

Packet tracking
- packetCount +1 on an accepted write with dataIn[WIDTH-1]=1.
- packetCount -1 on an accepted read of a word with MSB=1.
- If both occur in the same cycle, packetCount is unchanged.
- packetCount never exceeds count.

FWFT=0
- dataOut is registered. It takes the head word on the edge that accepts the read, so it is valid the cycle after readEnable.
- dataOut holds between reads.
- empty deasserts the cycle after the first write into an empty FIFO.

FWFT=1
- A prefetch output register holds the head word.
- empty=0 means dataOut is valid in the current cycle.
- Write into an empty FIFO: the word is on dataOut with empty=0 the following cycle.
- readEnable pops the presented word. The next word, or empty=1, appears on the next cycle.
- Back-to-back reads are sustained at one word per cycle.
- When empty=1, dataOut holds the last popped word.

Sticky flags
- overflow and underflow clear only on reset or flush.

Test Plan:
- Config for all scenarios: WIDTH=9, DEPTH=8, AFULL_LEVEL=6, FWFT=0.
- Fill and drain: write 0x001..0x008 -> full=1 and count=8 after the 8th write, almostFull=1 from count 6. Then read 8 times -> dataOut 0x001..0x008 in order, each one cycle after readEnable. empty=1 after the last read, count=0.
- Overflow and underflow: with the FIFO full, write 0x0AA -> overflow=1 and contents unchanged. Drain, then read once more -> underflow=1 and dataOut holds 0x008.
- Simultaneous operations and wrap: while full, write and read in the same cycle for 12 cycles -> count stays 8, pointers wrap, data order preserved. With the FIFO empty, write and read together -> the write is stored and underflow=1.
- Packet tracking: write 0x041, 0x042, 0x100 (EOP), 0x043, 0x101 (EEP) -> packetCount=2. Read three words -> packetCount=1, packetAvailable stays 1.
- FWFT=1: write 0x055 into an empty FIFO -> next cycle empty=0 and dataOut=0x055 with no readEnable. Assert readEnable continuously with 3 words stored -> one word per cycle, then empty=1.
- Reset and flush mid-operation: with 5 words stored and overflow=1, assert flush together with writeEnable and readEnable -> next cycle count=0, empty=1, overflow=0, dataOut=0 and nothing is written. Repeat using reset -> same result.
